// File: rtl/score_board_pkg.sv
// Shared types for the score_board: operand-lookup encoding and pipeline stage enum.
package score_board_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = $clog2(REG_NUM);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        SB_NONE = 2'd0,
        SB_EX   = 2'd1,
        SB_MEM  = 2'd2,
        SB_CMT  = 2'd3
    } sb_stage_e;

    // {stage, slot}: where the newest producer sits and which bypass lane carries it
    typedef struct packed {
        sb_stage_e stage;
        logic      slot;
    } sb_data_t;

endpackage

// File: rtl/score_board_if.sv
// Issue-side write port and operand-lookup port of the score_board.
interface score_board_if
    import score_board_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int QUERY_NUM   = 4
);
    logic      [ISSUE_WIDTH-1:0] issue_valid;
    logic      [ISSUE_WIDTH-1:0] issue_wb_ena;
    logic      [ISSUE_WIDTH-1:0] issue_is_load;
    reg_addr_t [ISSUE_WIDTH-1:0] issue_dst_addr;
    logic                        flush;
    reg_addr_t [QUERY_NUM-1:0]   query_addr;
    sb_data_t  [QUERY_NUM-1:0]   score_board_data;
    logic      [QUERY_NUM-1:0]   query_ready;

    modport master (
        output issue_valid, issue_wb_ena, issue_is_load, issue_dst_addr, flush, query_addr,
        input  score_board_data, query_ready
    );

    modport slave (
        input  issue_valid, issue_wb_ena, issue_is_load, issue_dst_addr, flush, query_addr,
        output score_board_data, query_ready
    );
endinterface

// File: rtl/score_board_entry.sv
// One tracked register: EX -> MEM -> CMT -> NONE walk, a new issue restarts it at EX.
module score_board_entry
    import score_board_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      hit,
    input  logic      hit_slot,
    input  logic      hit_load,
    output sb_stage_e stage,
    output logic      slot,
    output logic      load
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= SB_NONE;
            slot  <= 1'b0;
            load  <= 1'b0;
        end else if (flush) begin
            stage <= SB_NONE;
            slot  <= 1'b0;
            load  <= 1'b0;
        end else if (hit) begin
            // newest producer overrides whatever stage the old one reached
            stage <= SB_EX;
            slot  <= hit_slot;
            load  <= hit_load;
        end else begin
            case (stage)
                SB_EX:   stage <= SB_MEM;
                SB_MEM:  stage <= SB_CMT;
                SB_CMT: begin
                    stage <= SB_NONE;
                    slot  <= 1'b0;
                    load  <= 1'b0;
                end
                default: stage <= SB_NONE;
            endcase
        end
    end

endmodule

// File: rtl/score_board.sv
// Register scoreboard: tracks in-flight writes and answers operand lookups combinationally.
module score_board
    import score_board_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int QUERY_NUM   = 4
) (
    input logic          clk,
    input logic          rst_n,
    score_board_if.slave sb
);

    sb_data_t ent_data  [REG_NUM];
    logic     ent_stall [REG_NUM];

    // r0 is hardwired: never in flight, always readable
    assign ent_data[0]  = '{stage: SB_NONE, slot: 1'b0};
    assign ent_stall[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_ent
        logic      hit, hit_slot, hit_load;
        sb_stage_e stage;
        logic      slot, load;

        // higher slot is younger, so it is scanned last and wins
        always_comb begin
            hit      = 1'b0;
            hit_slot = 1'b0;
            hit_load = 1'b0;
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (sb.issue_valid[s] && sb.issue_wb_ena[s] &&
                    sb.issue_dst_addr[s] == REG_ADDR_W'(r)) begin
                    hit      = 1'b1;
                    hit_slot = s[0];
                    hit_load = sb.issue_is_load[s];
                end
            end
        end

        score_board_entry u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (sb.flush),
            .hit      (hit),
            .hit_slot (hit_slot),
            .hit_load (hit_load),
            .stage    (stage),
            .slot     (slot),
            .load     (load)
        );

        assign ent_data[r]  = '{stage: stage, slot: slot};
        assign ent_stall[r] = (stage == SB_EX) && load;
    end

    for (genvar q = 0; q < QUERY_NUM; q++) begin : g_query
        assign sb.score_board_data[q] = ent_data[sb.query_addr[q]];
        assign sb.query_ready[q]      = !ent_stall[sb.query_addr[q]];
    end

endmodule

// File: tb/tb_score_board.sv
// Directed vector bench for score_board: one-cycle issue vectors plus reset/collision sequences.
module tb_score_board;
    import score_board_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    score_board_if #(.ISSUE_WIDTH(2), .QUERY_NUM(4)) sb ();

    score_board #(.ISSUE_WIDTH(2), .QUERY_NUM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    typedef struct {
        logic [1:0]      v, wb, ld;
        logic [4:0]      d0, d1;
        logic            fl;
        logic [0:3][4:0] q;
        logic [0:3][2:0] e;
        logic [0:3]      r;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [1:0] v, wb, ld, input logic [4:0] d0, d1,
                                input logic fl, input logic [0:3][4:0] q,
                                input logic [0:3][2:0] e, input logic [0:3] r);
        vec_t t;
        t.v = v; t.wb = wb; t.ld = ld; t.d0 = d0; t.d1 = d1; t.fl = fl;
        t.q = q; t.e = e; t.r = r;
        return t;
    endfunction

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, wb, ld, input logic [4:0] d0, d1, input logic fl);
        sb.issue_valid       = v;
        sb.issue_wb_ena      = wb;
        sb.issue_is_load     = ld;
        sb.issue_dst_addr[0] = d0;
        sb.issue_dst_addr[1] = d1;
        sb.flush             = fl;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string name, input int p, input logic [2:0] e, input logic r);
        chk($sformatf("%s data q%0d", name, p), sb.score_board_data[p], e);
        chk($sformatf("%s ready q%0d", name, p), {2'b00, sb.query_ready[p]}, {2'b00, r});
    endtask

    initial begin
        // stage encodings: NONE=000 EX0=010 EX1=011 MEM0=100 MEM1=101 CMT0=110 CMT1=111
        vecs[0]  = mk(2'b00, 2'b00, 2'b00, 5'd0,  5'd0,  1'b0, {5'd1, 5'd2, 5'd3, 5'd31},
                      {3'b000, 3'b000, 3'b000, 3'b000}, 4'b1111);
        vecs[1]  = mk(2'b01, 2'b01, 2'b00, 5'd5,  5'd0,  1'b0, {5'd5, 5'd7, 5'd9, 5'd0},
                      {3'b010, 3'b000, 3'b000, 3'b000}, 4'b1111);
        vecs[2]  = mk(2'b10, 2'b10, 2'b10, 5'd0,  5'd7,  1'b0, {5'd5, 5'd7, 5'd9, 5'd0},
                      {3'b100, 3'b011, 3'b000, 3'b000}, 4'b1011);
        vecs[3]  = mk(2'b11, 2'b11, 2'b00, 5'd9,  5'd9,  1'b0, {5'd5, 5'd7, 5'd9, 5'd0},
                      {3'b110, 3'b101, 3'b011, 3'b000}, 4'b1111);
        vecs[4]  = mk(2'b01, 2'b01, 2'b00, 5'd9,  5'd0,  1'b0, {5'd5, 5'd7, 5'd9, 5'd0},
                      {3'b000, 3'b111, 3'b010, 3'b000}, 4'b1111);
        vecs[5]  = mk(2'b11, 2'b11, 2'b11, 5'd0,  5'd0,  1'b0, {5'd5, 5'd7, 5'd9, 5'd0},
                      {3'b000, 3'b000, 3'b100, 3'b000}, 4'b1111);
        vecs[6]  = mk(2'b11, 2'b11, 2'b10, 5'd4,  5'd8,  1'b0, {5'd4, 5'd8, 5'd9, 5'd0},
                      {3'b010, 3'b011, 3'b110, 3'b000}, 4'b1011);
        vecs[7]  = mk(2'b10, 2'b10, 2'b00, 5'd0,  5'd6,  1'b1, {5'd4, 5'd6, 5'd9, 5'd8},
                      {3'b000, 3'b000, 3'b000, 3'b000}, 4'b1111);
        vecs[8]  = mk(2'b11, 2'b00, 2'b11, 5'd3,  5'd3,  1'b0, {5'd3, 5'd4, 5'd6, 5'd31},
                      {3'b000, 3'b000, 3'b000, 3'b000}, 4'b1111);
        vecs[9]  = mk(2'b11, 2'b11, 2'b01, 5'd12, 5'd13, 1'b0, {5'd12, 5'd13, 5'd0, 5'd0},
                      {3'b010, 3'b011, 3'b000, 3'b000}, 4'b0111);
        vecs[10] = mk(2'b00, 2'b00, 2'b00, 5'd0,  5'd0,  1'b0, {5'd12, 5'd13, 5'd12, 5'd13},
                      {3'b100, 3'b101, 3'b100, 3'b101}, 4'b1111);

        idle();
        for (int p = 0; p < 4; p++) sb.query_addr[p] = 5'd0;
        #12 rst_n = 1'b1;
        tick();

        // each vector: inputs held across one clock edge, outputs checked just after it
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].wb, vecs[i].ld, vecs[i].d0, vecs[i].d1, vecs[i].fl);
            for (int p = 0; p < 4; p++) sb.query_addr[p] = vecs[i].q[p];
            tick();
            for (int p = 0; p < 4; p++)
                chk_port($sformatf("vec%0d", i), p, vecs[i].e[p], vecs[i].r[p]);
        end
        idle();

        // issue colliding with CMT->NONE advance: issue wins
        sb.query_addr[0] = 5'd21;
        drive(2'b01, 2'b01, 2'b00, 5'd21, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk_port("r21 cmt", 0, 3'b110, 1'b1);
        drive(2'b10, 2'b10, 2'b10, 5'd0, 5'd21, 1'b0);
        tick();
        idle();
        chk_port("r21 reissue", 0, 3'b011, 1'b0);
        tick();
        chk_port("r21 mem", 0, 3'b101, 1'b1);

        // mid-run asynchronous reset
        sb.query_addr[1] = 5'd20;
        drive(2'b01, 2'b01, 2'b01, 5'd20, 5'd0, 1'b0);
        tick();
        idle();
        chk_port("r20 ex load", 1, 3'b010, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_port("async rst r20", 1, 3'b000, 1'b1);
        chk_port("async rst r21", 0, 3'b000, 1'b1);
        tick();
        #3 rst_n = 1'b1;
        sb.query_addr[0] = 5'd1; sb.query_addr[1] = 5'd2;
        sb.query_addr[2] = 5'd3; sb.query_addr[3] = 5'd31;
        tick();
        for (int p = 0; p < 4; p++) chk_port("post rst", p, 3'b000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
